// File: rtl/plab4_net_pkg.sv
// Shared definitions for the ring-network router blocks.
//   PREV / TERM / NEXT : request/grant bit index of each input ctrl
//   c_num_reqs         : number of requesters per output port (reqs width)
//   rotl_onehot()      : rotate a vector left by one within its low n bits
package plab4_net_pkg;

    localparam int PREV = 0;
    localparam int TERM = 1;
    localparam int NEXT = 2;

    localparam int c_num_reqs = 3;

    // Working width for rotl_onehot(); callers zero-extend into it and
    // truncate back, so one function serves any requester count up to this.
    localparam int c_max_reqs = 16;

    // Bit n-1 wraps around to bit 0; bits at or above n are cleared.
    function automatic logic [c_max_reqs-1:0] rotl_onehot(
        input logic [c_max_reqs-1:0] v,
        input int                    n
    );
        logic [c_max_reqs-1:0] mask;
        mask = {c_max_reqs{1'b1}} >> (c_max_reqs - n);
        return ((v << 1) | (v >> (n - 1))) & mask;
    endfunction

endpackage

// File: rtl/plab4_net_rr_arb_core.sv
// Combinational variable-priority arbiter.
//   reqs       in   request vector
//   prio       in   one-hot: the bit where the search starts
//   grant      out  one-hot winner, zero when reqs == 0
//   grant_idx  out  index of the winner, zero when there is none
// The search starts at the prio bit and walks upward, wrapping from the top
// bit back to bit 0. Walking a doubled range covers the wrap without any
// modulo on a run-time value.
module plab4_net_rr_arb_core
    import plab4_net_pkg::*;
#(
    parameter  int p_num_reqs  = c_num_reqs,
    localparam int c_sel_nbits = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1
)(
    input  logic [p_num_reqs-1:0]  reqs,
    input  logic [p_num_reqs-1:0]  prio,
    output logic [p_num_reqs-1:0]  grant,
    output logic [c_sel_nbits-1:0] grant_idx
);

    logic armed;  // the prio bit has been passed in the walk
    logic found;  // a winner has been picked

    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is
        // inferred; blocking '=' lets later iterations see earlier updates.
        grant     = '0;
        grant_idx = '0;
        armed     = 1'b0;
        found     = 1'b0;
        for (int i = 0; i < 2 * p_num_reqs; i++) begin
            if (prio[i % p_num_reqs]) begin
                armed = 1'b1;
            end
            if (armed && !found && reqs[i % p_num_reqs]) begin
                found                  = 1'b1;
                grant[i % p_num_reqs]  = 1'b1;
                grant_idx              = c_sel_nbits'(i % p_num_reqs);
            end
        end
    end

endmodule

// File: rtl/plab4_net_router_output_ctrl.sv
// Per-output-port control of the ring router: round-robin arbitration among
// the input ctrls requesting this output, with one priority pointer per
// security domain so arbitration history never leaks across domains.
//   clk      in   clock
//   reset_n  in   asynchronous reset, active-low
//   cur_sd   in   current security domain (out of range -> domain 0)
//   reqs     in   request bit from each input ctrl (PREV, TERM, NEXT)
//   grants   out  one-hot grant, zero when no transfer happens this cycle
//   out_val  out  a message is offered downstream (independent of out_rdy)
//   out_rdy  in   downstream accepts the message
//   sel      out  crossbar select = index of the granted input, else 0
// The per-domain priority registers are the only state; every output is
// combinational from them and the inputs.
module plab4_net_router_output_ctrl
    import plab4_net_pkg::*;
#(
    parameter  int                    p_num_reqs       = c_num_reqs,
    parameter  int                    p_num_domains    = 2,
    parameter  logic [p_num_reqs-1:0] p_priority_reset = {{(p_num_reqs-1){1'b0}}, 1'b1},
    localparam int                    c_sel_nbits      = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1,
    localparam int                    c_sd_nbits       = (p_num_domains > 1) ? $clog2(p_num_domains) : 1
)(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [c_sd_nbits-1:0]  cur_sd,
    input  logic [p_num_reqs-1:0]  reqs,
    output logic [p_num_reqs-1:0]  grants,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [c_sel_nbits-1:0] sel
);

    logic [p_num_reqs-1:0]  prio_q [p_num_domains];
    logic [c_sd_nbits-1:0]  sd_idx;
    logic [p_num_reqs-1:0]  prio_cur;
    logic [p_num_reqs-1:0]  arb_grant;
    logic [c_sel_nbits-1:0] arb_idx;
    logic [p_num_reqs-1:0]  prio_next;
    logic                   xfer;

    // Domain labels beyond the register array fall back to domain 0.
    always_comb begin
        sd_idx = (int'(cur_sd) < p_num_domains) ? cur_sd : '0;
    end

    assign prio_cur = prio_q[sd_idx];

    plab4_net_rr_arb_core #(
        .p_num_reqs (p_num_reqs)
    ) u_arb (
        .reqs      (reqs),
        .prio      (prio_cur),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Outputs are gated by reset_n directly so they drop the moment reset
    // asserts, not at the next edge.
    assign out_val   = reset_n & (|reqs);
    assign grants    = (reset_n && out_rdy) ? arb_grant : '0;
    assign xfer      = |grants;
    assign sel       = xfer ? arb_idx : '0;

    // The input just after the winner gets first chance next time.
    assign prio_next = p_num_reqs'(rotl_onehot(c_max_reqs'(grants), p_num_reqs));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: this array is a handful of flops, not a RAM, so every
            // entry is reset; arbitration must start from a known pointer.
            for (int d = 0; d < p_num_domains; d++) begin
                prio_q[d] <= p_priority_reset;
            end
        end else if (xfer) begin
            prio_q[sd_idx] <= prio_next;
        end
    end

endmodule

// File: tb/tb_plab4_net_router_output_ctrl.sv
// Self-checking bench for plab4_net_router_output_ctrl. Each driven cycle
// pushes its expected outputs (from a small behavioural model) onto a
// scoreboard queue; the entry is popped and compared when the DUT outputs
// are sampled mid-cycle. Directed steps also compare against fixed values.
module tb_plab4_net_router_output_ctrl;

    logic       clk;
    logic       reset_n;
    logic       cur_sd;
    logic [2:0] reqs;
    logic [2:0] grants;
    logic       out_val;
    logic       out_rdy;
    logic [1:0] sel;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic [2:0] g;
        logic [1:0] s;
        logic       v;
    } exp_t;

    exp_t sb[$];

    // Reference model state: one-hot pointer per domain.
    logic [2:0] m_prio [2];

    plab4_net_router_output_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cur_sd  (cur_sd),
        .reqs    (reqs),
        .grants  (grants),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .sel     (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_prio[0] = 3'b001;
        m_prio[1] = 3'b001;
    endtask

    // Search from the pointer index upward, wrapping.
    task automatic model_eval(input logic [2:0] r, input logic rdy, input logic sd,
                              output logic [2:0] g, output logic [1:0] s);
        int start;
        int j;
        g = 3'b000;
        s = 2'd0;
        start = 0;
        for (int k = 0; k < 3; k++) if (m_prio[sd][k]) start = k;
        if (rdy) begin
            for (int k = 2; k >= 0; k--) begin
                j = (start + k) % 3;
                if (r[j]) begin
                    g = 3'b000;
                    g[j] = 1'b1;
                    s = 2'(j);
                end
            end
        end
    endtask

    // One clock cycle: drive after the falling edge, check mid-low phase,
    // then let the rising edge update the DUT (and the model).
    task automatic cycle(input logic [2:0] r, input logic rdy, input logic sd,
                         input string tag, input bit directed,
                         input logic [2:0] d_g, input logic [1:0] d_s);
        exp_t       e;
        logic [2:0] g;
        logic [1:0] s;
        @(negedge clk);
        reqs    = r;
        out_rdy = rdy;
        cur_sd  = sd;
        model_eval(r, rdy, sd, g, s);
        e.tag = tag;
        e.g   = g;
        e.s   = s;
        e.v   = |r;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        check({e.tag, ".grants"}, 32'(grants), 32'(e.g));
        check({e.tag, ".sel"},    32'(sel),    32'(e.s));
        check({e.tag, ".out_val"}, 32'(out_val), 32'(e.v));
        if (directed) begin
            check({tag, ".grants_fixed"}, 32'(grants), 32'(d_g));
            check({tag, ".sel_fixed"},    32'(sel),    32'(d_s));
        end
        if (|g) m_prio[sd] = {g[1:0], g[2]};
    endtask

    initial begin
        reset_n = 1'b0;
        reqs    = 3'b111;
        out_rdy = 1'b1;
        cur_sd  = 1'b0;
        model_reset();

        // 1. reset holds outputs low even with requests present
        repeat (2) @(negedge clk);
        #2;
        check("rst.grants",  32'(grants),  32'd0);
        check("rst.out_val", 32'(out_val), 32'd0);
        check("rst.sel",     32'(sel),     32'd0);
        reqs    = 3'b000;
        reset_n = 1'b1;

        // 2. rotation in domain 0
        cycle(3'b111, 1'b1, 1'b0, "rot0", 1, 3'b001, 2'd0);
        cycle(3'b111, 1'b1, 1'b0, "rot1", 1, 3'b010, 2'd1);
        cycle(3'b111, 1'b1, 1'b0, "rot2", 1, 3'b100, 2'd2);
        cycle(3'b111, 1'b1, 1'b0, "rot3", 1, 3'b001, 2'd0);

        // 3. backpressure: offered but not granted, pointer held
        cycle(3'b110, 1'b0, 1'b0, "bp0", 1, 3'b000, 2'd0);
        cycle(3'b110, 1'b0, 1'b0, "bp1", 1, 3'b000, 2'd0);
        cycle(3'b110, 1'b1, 1'b0, "bp2", 1, 3'b010, 2'd1);

        // 4. domain isolation (pointer 0 is now 100)
        cycle(3'b001, 1'b1, 1'b0, "iso0", 1, 3'b001, 2'd0);
        cycle(3'b111, 1'b1, 1'b1, "iso1", 1, 3'b001, 2'd0);
        cycle(3'b111, 1'b1, 1'b0, "iso2", 1, 3'b010, 2'd1);

        // 5. mid-operation reset (pointer 0 is now 100)
        @(negedge clk);
        reqs    = 3'b111;
        out_rdy = 1'b1;
        cur_sd  = 1'b0;
        #1;
        check("mrst.pre", 32'(grants), 32'b100);
        reset_n = 1'b0;
        #1;
        check("mrst.grants",  32'(grants),  32'd0);
        check("mrst.out_val", 32'(out_val), 32'd0);
        model_reset();
        @(negedge clk);
        reqs    = 3'b000;
        reset_n = 1'b1;
        cycle(3'b111, 1'b1, 1'b0, "mrst.after", 1, 3'b001, 2'd0);

        // 6. single persistent requester, pointer wraps to 001 afterwards
        cycle(3'b100, 1'b1, 1'b0, "one0", 1, 3'b100, 2'd2);
        cycle(3'b100, 1'b1, 1'b0, "one1", 1, 3'b100, 2'd2);
        cycle(3'b100, 1'b1, 1'b0, "one2", 1, 3'b100, 2'd2);
        cycle(3'b111, 1'b1, 1'b0, "one.after", 1, 3'b001, 2'd0);

        // Random traffic, domain toggling freely
        for (int n = 0; n < 300; n++) begin
            cycle(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), "rand", 0, 3'b000, 2'd0);
        end

        check("sb.empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
